// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding reads to a
// variable-latency instruction port, and buffers {pc+4, word} for decode.
module if_prefetch_stage #(
   parameter int unsigned DEPTH        = 2,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = 32'hF000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction,
   output logic        valid_out
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [31:0]   fetch_pc_r;
   logic [31:0]   req_addr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic [63:0]   queue_r [DEPTH];
   logic [63:0]   head_s;
   logic          push_s;
   logic          pop_s;
   logic          resp_s;
   logic          issue_s;

   // Queue handshakes, issue decision and next-state logic.
   always_comb begin
      state_s      = state_r;
      push_s       = (state_r == WAIT) && imem_valid && !branch_taken;
      pop_s        = (count_r != '0) && !freeze && !branch_taken;
      count_next_s = count_r + CW'(push_s) - CW'(pop_s);
      resp_s       = imem_valid && ((state_r == WAIT) || (state_r == DROP));
      // Issue only when a slot is guaranteed for the response.
      issue_s      = !rst && !branch_taken &&
                     ((state_r == IDLE) || resp_s) &&
                     (count_next_s < CW'(DEPTH));
      case (state_r)
         IDLE: begin
            if (issue_s) state_s = WAIT;
            else         state_s = IDLE;
         end
         WAIT: begin
            if (issue_s)           state_s = WAIT;
            else if (imem_valid)   state_s = IDLE;
            else if (branch_taken) state_s = DROP;
            else                   state_s = WAIT;
         end
         DROP: begin
            if (issue_s)         state_s = WAIT;
            else if (imem_valid) state_s = IDLE;
            else                 state_s = DROP;
         end
         default: state_s = IDLE;
      endcase
   end

   // Control state: FSM, fetch PC, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         req_addr_r <= 32'd0;
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         count_r    <= '0;
      end else begin
         state_r <= state_s;
         if (issue_s) begin
            req_addr_r <= fetch_pc_r;
         end else begin
            req_addr_r <= req_addr_r;
         end
         if (branch_taken) begin
            fetch_pc_r <= branch_addr;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
         end else begin
            if (issue_s) fetch_pc_r <= fetch_pc_r + 32'd4;
            else         fetch_pc_r <= fetch_pc_r;
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            else       rd_ptr_r <= rd_ptr_r;
            count_r <= count_next_s;
         end
      end
   end

   // Queue storage; contents are qualified by count so need no reset.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         queue_r[wr_ptr_r] <= {req_addr_r + 32'd4, imem_rdata};
      end
   end

   assign head_s      = queue_r[rd_ptr_r];
   assign valid_out   = (count_r != '0);
   assign pc_out      = valid_out ? head_s[63:32] : 32'd0;
   assign instruction = valid_out ? head_s[31:0]  : BUBBLE_INSTR;
   assign imem_req    = issue_s;
   assign imem_addr   = issue_s ? fetch_pc_r : 32'd0;

endmodule
